// File: rtl/adc128_responder_if.sv
// SPI-side signals of the ADC128S022-style link between an initiator
// (master: drives CS_N/SCLK/DIN) and the responder (slave: drives DOUT).
interface adc128_responder_if;
    logic adc_cs_n;
    logic adc_sclk;
    logic adc_saddr;
    logic adc_sdat;
    logic adc_sdat_oe;

    modport master (
        output adc_cs_n,
        output adc_sclk,
        output adc_saddr,
        input  adc_sdat,
        input  adc_sdat_oe
    );

    modport slave (
        input  adc_cs_n,
        input  adc_sclk,
        input  adc_saddr,
        output adc_sdat,
        output adc_sdat_oe
    );
endinterface

// File: rtl/adc128_responder.sv
// adc128_responder: emulates an 8-channel 12-bit ADC128S022 on the SPI side.
// Frames are 16 SCLK long; DIN carries the next channel address (bits 2..4),
// DOUT returns {4'b0, sample} of the channel addressed in the previous frame.
// All SPI inputs are synchronized and edge-detected on the local clk, which
// must run at least 8x SCLK. Holding CS_N low across frames gives continuous
// conversion.
// Optional macro ADC128_RESPONDER_TEST_PATTERN_EN: when defined, test_pattern=1
// replaces the sample with {4'b0, channel, 9-bit frame counter}.
module adc128_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIRST_CH    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    adc128_responder_if.slave        spi,
    input  logic [95:0]              ch_data,
    input  logic                     test_pattern,
    output logic                     frame_done,
    output logic                     frame_abort,
    output logic [2:0]               cur_ch
);

    localparam int unsigned STAGES   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [2:0]  RESET_CH = FIRST_CH[2:0];

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // ---------------------------------------------------------------- sync
    logic [STAGES-1:0] cs_sync;
    logic [STAGES-1:0] sclk_sync;
    logic [STAGES-1:0] saddr_sync;
    logic              cs_prev;
    logic              sclk_prev;

    // Synchronizer chains plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync    <= '1;
            sclk_sync  <= '1;
            saddr_sync <= '0;
            cs_prev    <= 1'b1;
            sclk_prev  <= 1'b1;
        end else begin
            cs_sync    <= {cs_sync[STAGES-2:0], spi.adc_cs_n};
            sclk_sync  <= {sclk_sync[STAGES-2:0], spi.adc_sclk};
            saddr_sync <= {saddr_sync[STAGES-2:0], spi.adc_saddr};
            cs_prev    <= cs_sync[STAGES-1];
            sclk_prev  <= sclk_sync[STAGES-1];
        end
    end

    logic cs_s;
    logic saddr_s;
    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;

    assign cs_s      = cs_sync[STAGES-1];
    assign saddr_s   = saddr_sync[STAGES-1];
    assign cs_fall   =  cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev &  cs_s;
    assign sclk_rise = ~sclk_prev &  sclk_sync[STAGES-1];
    assign sclk_fall =  sclk_prev & ~sclk_sync[STAGES-1];

    // ------------------------------------------------------------- samples
    logic [11:0] sample [8];

    for (genvar g = 0; g < 8; g++) begin : g_sample
        assign sample[g] = ch_data[12*g +: 12];
    end

    // ---------------------------------------------------------- registers
    state_t      state;
    state_t      state_n;
    logic [4:0]  bit_cnt;
    logic [4:0]  bit_cnt_n;
    logic [2:0]  addr;
    logic [2:0]  addr_n;
    logic [15:0] shreg;
    logic [15:0] shreg_n;
    logic [2:0]  pend_ch;
    logic [2:0]  pend_n;
    logic [2:0]  cur_ch_n;
    logic        sdat_q;
    logic        sdat_n;
    logic        oe_q;
    logic        oe_n;
    logic        done_n;
    logic        abort_n;
    logic [15:0] load_word;

`ifdef ADC128_RESPONDER_TEST_PATTERN_EN
    logic [8:0] frame_cnt;

    // Completed-frame counter feeding the test pattern; wraps at 512.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 9'd1;
        end
    end

    // Word loaded at frame start: test pattern or sample of the pending channel.
    always_comb begin
        load_word = {4'b0000, sample[pend_ch]};
        if (test_pattern) begin
            load_word = {4'b0000, pend_ch, frame_cnt};
        end
    end
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern;

    // Word loaded at frame start: sample of the pending channel.
    always_comb begin
        load_word = {4'b0000, sample[pend_ch]};
    end
`endif

    // State and datapath register update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            addr        <= '0;
            shreg       <= '0;
            pend_ch     <= RESET_CH;
            cur_ch      <= RESET_CH;
            sdat_q      <= 1'b0;
            oe_q        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            addr        <= addr_n;
            shreg       <= shreg_n;
            pend_ch     <= pend_n;
            cur_ch      <= cur_ch_n;
            sdat_q      <= sdat_n;
            oe_q        <= oe_n;
            frame_done  <= done_n;
            frame_abort <= abort_n;
        end
    end

    // Next-state logic; CS_N edges take priority over SCLK edges in the same clk.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        addr_n    = addr;
        shreg_n   = shreg;
        pend_n    = pend_ch;
        cur_ch_n  = cur_ch;
        sdat_n    = sdat_q;
        oe_n      = oe_q;
        done_n    = 1'b0;
        abort_n   = 1'b0;

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n   = SHIFT;
                    cur_ch_n  = pend_ch;
                    shreg_n   = load_word;
                    sdat_n    = load_word[15];
                    oe_n      = 1'b1;
                    bit_cnt_n = '0;
                    addr_n    = '0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                    sdat_n  = 1'b0;
                    abort_n = (bit_cnt < 5'd16);
                end else if (sclk_rise && (bit_cnt < 5'd16)) begin
                    if ((bit_cnt >= 5'd2) && (bit_cnt <= 5'd4)) begin
                        addr_n = {addr[1:0], saddr_s};
                    end
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd15) begin
                        pend_n = addr;
                        done_n = 1'b1;
                    end
                end else if (sclk_fall) begin
                    // A falling edge after bit 16 with CS_N held low starts
                    // the next frame without passing through IDLE.
                    if (bit_cnt == 5'd16) begin
                        if (!cs_s) begin
                            cur_ch_n  = pend_ch;
                            shreg_n   = load_word;
                            sdat_n    = load_word[15];
                            bit_cnt_n = '0;
                            addr_n    = '0;
                        end
                    end else if (bit_cnt != 5'd0) begin
                        shreg_n = {shreg[14:0], 1'b0};
                        sdat_n  = shreg[14];
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign spi.adc_sdat    = sdat_q;
    assign spi.adc_sdat_oe = oe_q;

endmodule

// File: tb/tb_adc128_responder.sv
// Self-checking bench for adc128_responder: a table of single frames from
// reset, hand-written continuous / reset-mid-frame / test-pattern sequences,
// and randomized frames checked against a frame-level reference model.
module tb_adc128_responder;

    localparam int HALF = 8;  // clk cycles per SCLK half period

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] ch_data;
    logic        test_pattern;
    logic        frame_done;
    logic        frame_abort;
    logic [2:0]  cur_ch;

    adc128_responder_if spi ();

    adc128_responder #(
        .SYNC_STAGES (2),
        .FIRST_CH    (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (spi),
        .ch_data      (ch_data),
        .test_pattern (test_pattern),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .cur_ch       (cur_ch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    int abort_pulses = 0;
    int both_high = 0;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_pulses++;
        if (frame_abort === 1'b1) abort_pulses++;
        if (frame_done === 1'b1 && frame_abort === 1'b1) both_high++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------ reference model
    logic [2:0] m_pend;
    int         m_cnt;

    // Frame-level view: every 16 bits starts from the pending channel; DIN
    // bits 2..4 of each 16 form the next pending channel.
    task automatic predict(input int n, input logic [31:0] din, input logic tp,
                           output logic [31:0] rx, output int done, output int abort,
                           output logic [2:0] ch);
        logic [15:0] w;
        logic [2:0]  a;
        int          pos;
        rx = '0; done = 0; abort = 0; ch = m_pend; w = '0; a = '0;
        for (int i = 0; i < n; i++) begin
            pos = i % 16;
            if (pos == 0) begin
                ch = m_pend;
                if (tp) w = {4'b0000, ch, m_cnt[8:0]};
                else    w = {4'b0000, ch_data[int'(ch)*12 +: 12]};
                a = '0;
            end
            rx = {rx[30:0], w[15-pos]};
            if (pos >= 2 && pos <= 4) a = {a[1:0], din[31-i]};
            if (pos == 15) begin
                m_pend = a;
                m_cnt  = (m_cnt + 1) % 512;
                done++;
            end
        end
        if (n % 16 != 0) abort = 1;
    endtask

    function automatic logic [31:0] mk_din(input logic [2:0] a1, input logic [2:0] a2);
        return {2'b00, a1, 11'd0, 2'b00, a2, 11'd0};
    endfunction

    // ------------------------------------------------------------ SPI master
    task automatic do_frame(input int n, input logic [31:0] din,
                            output logic [31:0] rx, output int oe_low);
        rx = '0; oe_low = 0;
        spi.adc_cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < n; i++) begin
            spi.adc_sclk  = 1'b0;
            spi.adc_saddr = din[31-i];
            wait_clk(HALF);
            rx = {rx[30:0], spi.adc_sdat};
            if (spi.adc_sdat_oe !== 1'b1) oe_low++;
            spi.adc_sclk = 1'b1;
            wait_clk(HALF);
        end
        spi.adc_cs_n = 1'b1;
        wait_clk(2*HALF);
    endtask

    task automatic model_frame(input string tag, input int n, input logic [31:0] din, input logic tp);
        logic [31:0] erx, rx;
        int          edone, eabort, oe_low, d0, a0;
        logic [2:0]  ech;
        test_pattern = tp;
        predict(n, din, tp, erx, edone, eabort, ech);
        d0 = done_pulses; a0 = abort_pulses;
        do_frame(n, din, rx, oe_low);
        chk({tag, " dout"}, rx, erx);
        chk({tag, " done"}, done_pulses - d0, edone);
        chk({tag, " abort"}, abort_pulses - a0, eabort);
        chk({tag, " cur_ch"}, {29'd0, cur_ch}, {29'd0, ech});
        chk({tag, " oe"}, {31'd0, spi.adc_sdat_oe}, 32'd0);
    endtask

    // ----------------------------------------------------------- vector table
    typedef struct {
        logic [2:0]  ch;
        logic [11:0] sample;
        logic [2:0]  addr;
        int          nbits;
        logic [31:0] exp_rx;
        int          exp_done;
        int          exp_abort;
        logic [2:0]  exp_cur;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] rx, erx;
        int          oe_low, d0, a0, edone, eabort;
        logic [2:0]  ech;
        logic [31:0] din;

        vecs[0] = '{3'd0, 12'hABC, 3'd3, 16, 32'h0000_0ABC, 1, 0, 3'd0};
        vecs[1] = '{3'd3, 12'h5A5, 3'd7, 16, 32'h0000_05A5, 1, 0, 3'd3};
        vecs[2] = '{3'd7, 12'hFFF, 3'd6,  9, 32'h0000_001F, 0, 1, 3'd7};
        vecs[3] = '{3'd7, 12'h001, 3'd0, 16, 32'h0000_0001, 1, 0, 3'd7};
        vecs[4] = '{3'd0, 12'h800, 3'd5, 16, 32'h0000_0800, 1, 0, 3'd0};
        vecs[5] = '{3'd5, 12'h123, 3'd2, 16, 32'h0000_0123, 1, 0, 3'd5};

        reset = 1'b1;
        spi.adc_cs_n = 1'b1; spi.adc_sclk = 1'b1; spi.adc_saddr = 1'b0;
        ch_data = '0; test_pattern = 1'b0;
        m_pend = 3'd0; m_cnt = 0;
        wait_clk(3);
        chk("reset sdat", {31'd0, spi.adc_sdat}, 32'd0);
        chk("reset oe", {31'd0, spi.adc_sdat_oe}, 32'd0);
        chk("reset done", {31'd0, frame_done}, 32'd0);
        chk("reset abort", {31'd0, frame_abort}, 32'd0);
        chk("reset cur_ch", {29'd0, cur_ch}, 32'd0);
        reset = 1'b0;
        wait_clk(4);

        // Table: single frames (normal and aborted) chained from reset.
        for (int v = 0; v < 6; v++) begin
            ch_data = {$urandom, $urandom, $urandom};
            ch_data[int'(vecs[v].ch)*12 +: 12] = vecs[v].sample;
            din = mk_din(vecs[v].addr, 3'd0);
            predict(vecs[v].nbits, din, 1'b0, erx, edone, eabort, ech);
            d0 = done_pulses; a0 = abort_pulses;
            do_frame(vecs[v].nbits, din, rx, oe_low);
            chk($sformatf("vec%0d dout", v), rx, vecs[v].exp_rx);
            chk($sformatf("vec%0d done", v), done_pulses - d0, vecs[v].exp_done);
            chk($sformatf("vec%0d abort", v), abort_pulses - a0, vecs[v].exp_abort);
            chk($sformatf("vec%0d cur_ch", v), {29'd0, cur_ch}, {29'd0, vecs[v].exp_cur});
            chk($sformatf("vec%0d oe_after", v), {31'd0, spi.adc_sdat_oe}, 32'd0);
        end

        // Continuous mode: 32 SCLK under one CS_N, addresses 2 then 5.
        ch_data = {$urandom, $urandom, $urandom};
        ch_data[2*12 +: 12] = 12'h111;
        ch_data[5*12 +: 12] = 12'h222;
        din = mk_din(3'd2, 3'd5);
        predict(32, din, 1'b0, erx, edone, eabort, ech);
        d0 = done_pulses; a0 = abort_pulses;
        do_frame(32, din, rx, oe_low);
        chk("cont dout", rx, 32'h0111_0111);
        chk("cont done", done_pulses - d0, 2);
        chk("cont abort", abort_pulses - a0, 0);
        chk("cont oe_gap", oe_low, 0);
        chk("cont cur_ch", {29'd0, cur_ch}, 32'd2);

        // Reset asserted after 7 SCLK of a frame.
        a0 = abort_pulses;
        spi.adc_cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 7; i++) begin
            spi.adc_sclk = 1'b0; spi.adc_saddr = 1'b1;
            wait_clk(HALF);
            spi.adc_sclk = 1'b1;
            wait_clk(HALF);
        end
        reset = 1'b1;
        #1;
        chk("midrst sdat", {31'd0, spi.adc_sdat}, 32'd0);
        chk("midrst oe", {31'd0, spi.adc_sdat_oe}, 32'd0);
        chk("midrst done", {31'd0, frame_done}, 32'd0);
        chk("midrst abort", {31'd0, frame_abort}, 32'd0);
        chk("midrst cur_ch", {29'd0, cur_ch}, 32'd0);
        spi.adc_cs_n = 1'b1; spi.adc_sclk = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        m_pend = 3'd0; m_cnt = 0;
        wait_clk(4);
        chk("midrst no_abort", abort_pulses - a0, 0);
        ch_data = {$urandom, $urandom, $urandom};
        model_frame("after_rst", 16, mk_din(3'd4, 3'd0), 1'b0);
        chk("after_rst ch0", {29'd0, cur_ch}, 32'd0);

`ifdef ADC128_RESPONDER_TEST_PATTERN_EN
        // Test pattern: three frames with address 1 after a fresh reset.
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        m_pend = 3'd0; m_cnt = 0;
        wait_clk(4);
        test_pattern = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] tp_exp [3];
            logic [2:0]  tp_ch  [3];
            tp_exp[0] = 32'h0000; tp_exp[1] = 32'h0201; tp_exp[2] = 32'h0202;
            tp_ch[0] = 3'd0; tp_ch[1] = 3'd1; tp_ch[2] = 3'd1;
            din = mk_din(3'd1, 3'd0);
            predict(16, din, 1'b1, erx, edone, eabort, ech);
            do_frame(16, din, rx, oe_low);
            chk($sformatf("tp%0d dout", k), rx, tp_exp[k]);
            chk($sformatf("tp%0d cur_ch", k), {29'd0, cur_ch}, {29'd0, tp_ch[k]});
        end
        test_pattern = 1'b0;
`endif

        // Randomized frames: lengths, addresses, DIN noise and samples.
        for (int r = 0; r < 24; r++) begin
            int          sel, n;
            logic        tp;
            logic [31:0] rdin;
            sel = $urandom_range(0, 9);
            if (sel < 6)      n = 16;
            else if (sel < 8) n = 32;
            else              n = $urandom_range(1, 15);
            rdin = $urandom;
            ch_data = {$urandom, $urandom, $urandom};
`ifdef ADC128_RESPONDER_TEST_PATTERN_EN
            tp = 1'($urandom_range(0, 1));
`else
            tp = 1'b0;
`endif
            model_frame($sformatf("rnd%0d", r), n, rdin, tp);
        end

        chk("never_both", both_high, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
